// File: rtl/cordic_iter.sv
// Folded CORDIC: a single shift/add stage reused for N_ITER cycles, then one gain-compensation cycle.
// Vectoring requests record their direction codes and quadrant flag; rotation requests replay them.
module cordic_iter #(
   parameter int C_IWL  = 5,
   parameter int C_FWL  = 15,
   parameter int N_ITER = 15,
   parameter int GAIN   = 19898,
   localparam int W     = C_IWL + C_FWL
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic         i_valid,
   output logic         o_ready,
   input  logic         i_vectoring_mode,
   input  logic [W-1:0] i_X,
   input  logic [W-1:0] i_Y,
   output logic         o_valid,
   input  logic         i_ready,
   output logic [W-1:0] o_X,
   output logic [W-1:0] o_Y,
   output logic         o_vectoring_mode
);

   localparam int KW = (N_ITER > 1) ? $clog2(N_ITER) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(N_ITER - 1);
   localparam int PW = W + C_FWL + 1;

   // Direction codes: 00 = no rotation, 01 = +1, 11 = -1.
   localparam logic [1:0] U_ZERO = 2'b00;
   localparam logic [1:0] U_POS  = 2'b01;
   localparam logic [1:0] U_NEG  = 2'b11;

   typedef enum logic [1:0] {IDLE, ITER, SCALE, DONE} state_t;

   state_t state, state_nx;

   logic signed [W-1:0]  x, y, x_sh, y_sh, x_nx, y_nx, x_in, y_in;
   logic signed [PW-1:0] gain_s, prod_x, prod_y;
   logic [N_ITER-1:0][1:0] codes;
   logic [1:0]           u;
   logic [KW-1:0]        k;
   logic                 mode, qflag, q_in;

   // FSM: state register
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) state <= IDLE;
      else        state <= state_nx;
   end

   // FSM: next state
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (i_valid)     state_nx = ITER;
         ITER:    if (k == K_LAST) state_nx = SCALE;
         SCALE:                    state_nx = DONE;
         DONE:    if (i_ready)     state_nx = IDLE;
         default:                  state_nx = IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      o_ready = (state == IDLE);
      o_valid = (state == DONE);
   end

   // Left-half-plane operands are folded into the right half by negation.
   assign q_in = i_vectoring_mode ? i_X[W-1] : qflag;
   assign x_in = q_in ? -$signed(i_X) : $signed(i_X);
   assign y_in = q_in ? -$signed(i_Y) : $signed(i_Y);

   assign x_sh = x >>> k;
   assign y_sh = y >>> k;

   always_comb begin
      u = codes[k];
      if (mode) begin
         if (y == '0)    u = U_ZERO;
         else if (y[W-1]) u = U_POS;
         else            u = U_NEG;
      end
   end

   always_comb begin
      x_nx = x;
      y_nx = y;
      case (u)
         U_POS: begin x_nx = x - y_sh; y_nx = y + x_sh; end
         U_NEG: begin x_nx = x + y_sh; y_nx = y - x_sh; end
         default: ;
      endcase
   end

   assign gain_s = PW'(GAIN);
   assign prod_x = PW'(x) * gain_s;
   assign prod_y = PW'(y) * gain_s;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         x                <= '0;
         y                <= '0;
         k                <= '0;
         mode             <= 1'b0;
         qflag            <= 1'b0;
         codes            <= '0;
         o_X              <= '0;
         o_Y              <= '0;
         o_vectoring_mode <= 1'b0;
      end else begin
         case (state)
            IDLE: if (i_valid) begin
               mode <= i_vectoring_mode;
               x    <= x_in;
               y    <= y_in;
               k    <= '0;
               if (i_vectoring_mode) qflag <= q_in;
            end
            ITER: begin
               x <= x_nx;
               y <= y_nx;
               k <= k + 1'b1;
               if (mode) codes[k] <= u;
            end
            SCALE: begin
               o_X              <= W'(prod_x >>> C_FWL);
               o_Y              <= mode ? '0 : W'(prod_y >>> C_FWL);
               o_vectoring_mode <= mode;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cordic_iter.sv
// Directed bench for cordic_iter at default parameters (1.0 = 32768, tolerance +/-8 LSB on CORDIC results).
module tb_cordic_iter;

   localparam int W   = 20;
   localparam int TOL = 8;

   logic         Clk = 1'b0;
   logic         Reset = 1'b0;
   logic         i_valid = 1'b0;
   logic         o_ready;
   logic         i_vectoring_mode = 1'b0;
   logic [W-1:0] i_X = '0;
   logic [W-1:0] i_Y = '0;
   logic         o_valid;
   logic         i_ready = 1'b0;
   logic [W-1:0] o_X;
   logic [W-1:0] o_Y;
   logic         o_vectoring_mode;

   int checks = 0;
   int errors = 0;

   cordic_iter dut (
      .Clk(Clk), .Reset(Reset), .i_valid(i_valid), .o_ready(o_ready),
      .i_vectoring_mode(i_vectoring_mode), .i_X(i_X), .i_Y(i_Y),
      .o_valid(o_valid), .i_ready(i_ready), .o_X(o_X), .o_Y(o_Y),
      .o_vectoring_mode(o_vectoring_mode)
   );

   always #5 Clk = ~Clk;

   function automatic int sx(input logic [W-1:0] v);
      return int'($signed(v));
   endfunction

   // Present a request for one edge (DUT must be idle), then scramble the inputs.
   task automatic apply_req(input bit vec, input int x, input int y);
      @(negedge Clk);
      i_valid = 1'b1; i_vectoring_mode = vec; i_X = W'(x); i_Y = W'(y);
      @(posedge Clk); #1;
      i_valid = 1'b0; i_vectoring_mode = ~vec; i_X = W'(12345); i_Y = W'(-777);
   endtask

   // Counts the accepting edge as edge 1; returns the edge count at which o_valid is seen.
   task automatic wait_valid(output int lat);
      lat = 1;
      while (!o_valid && lat < 40) begin
         @(posedge Clk); #1;
         lat++;
      end
   endtask

   task automatic release_result();
      @(negedge Clk); i_ready = 1'b1;
      @(posedge Clk); #1; i_ready = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", o_valid); end
      repeat (2) @(negedge Clk);
      Reset = 1'b1;
      @(posedge Clk); #1;
      checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", o_ready); end
      checks++; if (o_X !== '0 || o_Y !== '0 || o_vectoring_mode !== 1'b0)
         begin errors++; $display("FAIL rst_outs: got X=%0d Y=%0d m=%b want 0 0 0", sx(o_X), sx(o_Y), o_vectoring_mode); end
   endtask

   task automatic test_rot_nomem();
      int lat;
      apply_req(1'b0, 32768, 0);
      wait_valid(lat);
      checks++; if (lat != 17) begin errors++; $display("FAIL rot0_latency: got %0d want 17", lat); end
      checks++; if (sx(o_X) != 19898 || sx(o_Y) != 0)
         begin errors++; $display("FAIL rot0_value: got X=%0d Y=%0d want 19898 0", sx(o_X), sx(o_Y)); end
      checks++; if (o_vectoring_mode !== 1'b0) begin errors++; $display("FAIL rot0_mode: got %b want 0", o_vectoring_mode); end
      release_result();
   endtask

   task automatic test_vec_q1();
      int lat;
      apply_req(1'b1, 98304, 131072);
      wait_valid(lat);
      checks++; if (sx(o_X) - 163840 > TOL || sx(o_X) - 163840 < -TOL)
         begin errors++; $display("FAIL vec34_mag: got %0d want 163840", sx(o_X)); end
      checks++; if (sx(o_Y) != 0 || o_vectoring_mode !== 1'b1)
         begin errors++; $display("FAIL vec34_ymode: got Y=%0d m=%b want 0 1", sx(o_Y), o_vectoring_mode); end
      release_result();
      apply_req(1'b0, 32768, 0);
      wait_valid(lat);
      checks++; if (sx(o_X) - 19661 > TOL || sx(o_X) - 19661 < -TOL || sx(o_Y) + 26214 > TOL || sx(o_Y) + 26214 < -TOL)
         begin errors++; $display("FAIL rot34: got X=%0d Y=%0d want 19661 -26214", sx(o_X), sx(o_Y)); end
      release_result();
   endtask

   task automatic test_vec_q3();
      int lat;
      apply_req(1'b1, -98304, -131072);
      wait_valid(lat);
      checks++; if (sx(o_X) - 163840 > TOL || sx(o_X) - 163840 < -TOL || sx(o_Y) != 0)
         begin errors++; $display("FAIL vecq3: got X=%0d Y=%0d want 163840 0", sx(o_X), sx(o_Y)); end
      release_result();
      apply_req(1'b0, 32768, 0);
      wait_valid(lat);
      checks++; if (sx(o_X) + 19661 > TOL || sx(o_X) + 19661 < -TOL || sx(o_Y) - 26214 > TOL || sx(o_Y) - 26214 < -TOL)
         begin errors++; $display("FAIL rotq3: got X=%0d Y=%0d want -19661 26214", sx(o_X), sx(o_Y)); end
      release_result();
   endtask

   task automatic test_hold();
      int lat;
      apply_req(1'b0, 32768, 0);
      wait_valid(lat);
      for (int c = 0; c < 5; c++) begin
         @(negedge Clk);
         i_valid = (c % 2 == 0); i_vectoring_mode = 1'b1; i_X = W'(c * 1000); i_Y = W'(-5000);
         @(posedge Clk); #1;
         checks++; if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_vectoring_mode !== 1'b0 ||
                       sx(o_X) + 19661 > TOL || sx(o_X) + 19661 < -TOL || sx(o_Y) - 26214 > TOL || sx(o_Y) - 26214 < -TOL)
            begin errors++; $display("FAIL hold_c%0d: got v=%b r=%b X=%0d Y=%0d want 1 0 -19661 26214", c, o_valid, o_ready, sx(o_X), sx(o_Y)); end
      end
      @(negedge Clk); i_valid = 1'b0; i_ready = 1'b1;
      @(posedge Clk); #1; i_ready = 1'b0;
      checks++; if (o_valid !== 1'b0 || o_ready !== 1'b1)
         begin errors++; $display("FAIL hold_release: got v=%b r=%b want 0 1", o_valid, o_ready); end
      repeat (3) @(posedge Clk); #1;
      checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL hold_no_accept: got r=%b want 1", o_ready); end
   endtask

   task automatic test_reset_mid();
      int lat;
      bit seen;
      apply_req(1'b1, 98304, 131072);
      repeat (7) @(posedge Clk);
      #1 Reset = 1'b0;
      #1;
      checks++; if (o_valid !== 1'b0 || o_X !== '0 || o_Y !== '0 || o_vectoring_mode !== 1'b0)
         begin errors++; $display("FAIL midrst_outs: got v=%b X=%0d Y=%0d m=%b want 0 0 0 0", o_valid, sx(o_X), sx(o_Y), o_vectoring_mode); end
      @(negedge Clk); Reset = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(posedge Clk); #1;
         if (o_valid) seen = 1'b1;
      end
      checks++; if (seen || o_ready !== 1'b1)
         begin errors++; $display("FAIL midrst_discard: got seen=%b r=%b want 0 1", seen, o_ready); end
      apply_req(1'b0, 32768, 0);
      wait_valid(lat);
      checks++; if (sx(o_X) != 19898 || sx(o_Y) != 0)
         begin errors++; $display("FAIL midrst_rot: got X=%0d Y=%0d want 19898 0", sx(o_X), sx(o_Y)); end
      release_result();
   endtask

   task automatic test_back_to_back();
      int acc[3];
      int n = 0;
      int cyc = 0;
      bit val_ok = 1'b1;
      @(negedge Clk);
      i_ready = 1'b1; i_valid = 1'b1; i_vectoring_mode = 1'b0; i_X = W'(32768); i_Y = '0;
      while (n < 3 && cyc < 100) begin
         if (o_ready && i_valid) begin acc[n] = cyc; n++; end
         if (o_valid && (sx(o_X) != 19898 || sx(o_Y) != 0)) val_ok = 1'b0;
         @(negedge Clk);
         cyc++;
      end
      i_valid = 1'b0;
      checks++; if (n != 3) begin errors++; $display("FAIL b2b_count: got %0d want 3", n); end
      else begin
         checks++; if (acc[1] - acc[0] != 18 || acc[2] - acc[1] != 18)
            begin errors++; $display("FAIL b2b_spacing: got %0d %0d want 18 18", acc[1] - acc[0], acc[2] - acc[1]); end
      end
      checks++; if (!val_ok) begin errors++; $display("FAIL b2b_value: got wrong result want 19898 0"); end
      repeat (20) @(negedge Clk);
      i_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_rot_nomem();
      test_vec_q1();
      test_vec_q3();
      test_hold();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
